// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 scan-code constants, prefix FSM encoding and small decode helpers
// for the keyboard decoder slice.
package ps2_key_decoder_pkg;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;
   localparam logic [7:0] PS2_E1 = 8'hE1;
   localparam logic [7:0] PS2_AA = 8'hAA;
   localparam logic [7:0] PS2_FA = 8'hFA;
   localparam logic [7:0] PS2_FE = 8'hFE;
   localparam logic [7:0] PS2_EE = 8'hEE;

   localparam logic [7:0] KEY_LSHIFT = 8'h12;
   localparam logic [7:0] KEY_RSHIFT = 8'h59;
   localparam logic [7:0] KEY_CTRL   = 8'h14;
   localparam logic [7:0] KEY_CAPS   = 8'h58;

   localparam logic [7:0] ASCII_NONE     = 8'hFF;
   localparam logic [7:0] ASCII_UNMAPPED = 8'hF1;

   // Bytes that follow E1 in the Pause make sequence
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_PAUSE  = 3'd4
   } pfx_state_t;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
   endfunction

   // Keyboard responses / BAT codes that carry no key information
   function automatic logic is_ignored(input logic [7:0] c);
      return (c == PS2_AA) || (c == PS2_FA) || (c == PS2_FE) ||
             (c == PS2_EE) || (c == 8'h00)  || (c == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// First-word-fall-through character FIFO; head is visible on o_rd_data while
// not empty. A write into a full FIFO is accepted only if a pop happens too.
module ps2_char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd    = i_rd_en & ~o_empty;
   assign w_wr    = i_wr_en & (~o_full | w_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/ps2ascii.sv
// Combinational scan-code set 2 to ASCII lookup. Returns ASCII_NONE for unknown
// codes and ASCII_UNMAPPED for known keys that have no character.
module ps2ascii
   import ps2_key_decoder_pkg::*;
(
   input  logic       i_shift,
   input  logic       i_extend,
   input  logic [7:0] i_code,
   output logic [7:0] o_ascii
);

   logic [15:0] w_pair;   // {unshifted, shifted}

   always_comb begin
      w_pair = {ASCII_NONE, ASCII_NONE};
      if (i_extend) begin
         case (i_code)
            8'h4A: w_pair = {8'h2F, 8'h2F};
            8'h5A: w_pair = {8'h0D, 8'h0D};
            8'h71: w_pair = {8'h7F, 8'h7F};
            8'h75, 8'h72, 8'h6B, 8'h74,
            8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70: w_pair = {ASCII_UNMAPPED, ASCII_UNMAPPED};
            default: w_pair = {ASCII_NONE, ASCII_NONE};
         endcase
      end else begin
         case (i_code)
            8'h1C: w_pair = {8'h61, 8'h41};  8'h32: w_pair = {8'h62, 8'h42};
            8'h21: w_pair = {8'h63, 8'h43};  8'h23: w_pair = {8'h64, 8'h44};
            8'h24: w_pair = {8'h65, 8'h45};  8'h2B: w_pair = {8'h66, 8'h46};
            8'h34: w_pair = {8'h67, 8'h47};  8'h33: w_pair = {8'h68, 8'h48};
            8'h43: w_pair = {8'h69, 8'h49};  8'h3B: w_pair = {8'h6A, 8'h4A};
            8'h42: w_pair = {8'h6B, 8'h4B};  8'h4B: w_pair = {8'h6C, 8'h4C};
            8'h3A: w_pair = {8'h6D, 8'h4D};  8'h31: w_pair = {8'h6E, 8'h4E};
            8'h44: w_pair = {8'h6F, 8'h4F};  8'h4D: w_pair = {8'h70, 8'h50};
            8'h15: w_pair = {8'h71, 8'h51};  8'h2D: w_pair = {8'h72, 8'h52};
            8'h1B: w_pair = {8'h73, 8'h53};  8'h2C: w_pair = {8'h74, 8'h54};
            8'h3C: w_pair = {8'h75, 8'h55};  8'h2A: w_pair = {8'h76, 8'h56};
            8'h1D: w_pair = {8'h77, 8'h57};  8'h22: w_pair = {8'h78, 8'h58};
            8'h35: w_pair = {8'h79, 8'h59};  8'h1A: w_pair = {8'h7A, 8'h5A};
            8'h45: w_pair = {8'h30, 8'h29};  8'h16: w_pair = {8'h31, 8'h21};
            8'h1E: w_pair = {8'h32, 8'h40};  8'h26: w_pair = {8'h33, 8'h23};
            8'h25: w_pair = {8'h34, 8'h24};  8'h2E: w_pair = {8'h35, 8'h25};
            8'h36: w_pair = {8'h36, 8'h5E};  8'h3D: w_pair = {8'h37, 8'h26};
            8'h3E: w_pair = {8'h38, 8'h2A};  8'h46: w_pair = {8'h39, 8'h28};
            8'h0E: w_pair = {8'h60, 8'h7E};  8'h4E: w_pair = {8'h2D, 8'h5F};
            8'h55: w_pair = {8'h3D, 8'h2B};  8'h54: w_pair = {8'h5B, 8'h7B};
            8'h5B: w_pair = {8'h5D, 8'h7D};  8'h5D: w_pair = {8'h5C, 8'h7C};
            8'h4C: w_pair = {8'h3B, 8'h3A};  8'h52: w_pair = {8'h27, 8'h22};
            8'h41: w_pair = {8'h2C, 8'h3C};  8'h49: w_pair = {8'h2E, 8'h3E};
            8'h4A: w_pair = {8'h2F, 8'h3F};  8'h29: w_pair = {8'h20, 8'h20};
            8'h5A: w_pair = {8'h0D, 8'h0D};  8'h66: w_pair = {8'h08, 8'h08};
            8'h0D: w_pair = {8'h09, 8'h09};  8'h76: w_pair = {8'h1B, 8'h1B};
            8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
            8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07: w_pair = {ASCII_UNMAPPED, ASCII_UNMAPPED};
            default: w_pair = {ASCII_NONE, ASCII_NONE};
         endcase
      end
      o_ascii = i_shift ? w_pair[7:0] : w_pair[15:8];
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM, modifier/caps tracking, case and ctrl
// adjustment, and a character FIFO towards the CPU I/O port.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | waiting for a key code or prefix
//   ST_EXT    | E0 seen; next byte is an extended make (or F0)
//   ST_BRK    | F0 seen; next byte is a normal break
//   ST_EXTBRK | E0 F0 seen; next byte is an extended break
//   ST_PAUSE  | inside the Pause sequence; r_skip bytes left to swallow
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int CAPS_ENABLE = 1,
   parameter int CTRL_ENABLE = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [7:0]                      code_in,
   input  logic                            code_valid,
   output logic [7:0]                      ascii_data,
   output logic                            ascii_valid,
   input  logic                            ascii_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            caps_lock,
   output logic                            mod_shift,
   output logic                            mod_ctrl,
   output logic                            overflow,
   input  logic                            overflow_clr
);

   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Reset asserts immediately, releases two clocks later in this domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   pfx_state_t r_state, w_state_nxt;
   logic [2:0] r_skip, w_skip_nxt;
   logic       w_make, w_brk, w_ext;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= ST_IDLE;
         r_skip  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_skip  <= w_skip_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip;
      w_make      = 1'b0;
      w_brk       = 1'b0;
      w_ext       = 1'b0;
      if (code_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (code_in == PS2_E0)      w_state_nxt = ST_EXT;
               else if (code_in == PS2_F0) w_state_nxt = ST_BRK;
               else if (code_in == PS2_E1) begin
                  w_state_nxt = ST_PAUSE;
                  w_skip_nxt  = PAUSE_SKIP;
               end else if (!is_ignored(code_in)) w_make = 1'b1;
            end
            ST_EXT: begin
               if (code_in == PS2_F0) w_state_nxt = ST_EXTBRK;
               else begin
                  w_make      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_brk       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_EXTBRK: begin
               w_brk       = 1'b1;
               w_ext       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_PAUSE: begin
               w_skip_nxt = r_skip - 3'd1;
               if (r_skip == 3'd1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   logic w_is_lshift, w_is_rshift, w_is_fake_shift;
   logic w_is_lctrl, w_is_rctrl, w_is_caps, w_is_mod;
   logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps, r_caps_held;

   assign w_is_lshift     = (code_in == KEY_LSHIFT) & ~w_ext;
   assign w_is_fake_shift = (code_in == KEY_LSHIFT) &  w_ext;
   assign w_is_rshift     = (code_in == KEY_RSHIFT) & ~w_ext;
   assign w_is_lctrl      = (code_in == KEY_CTRL)   & ~w_ext;
   assign w_is_rctrl      = (code_in == KEY_CTRL)   &  w_ext;
   assign w_is_caps       = (code_in == KEY_CAPS)   & ~w_ext;
   assign w_is_mod        = w_is_lshift | w_is_rshift | w_is_fake_shift |
                            w_is_lctrl  | w_is_rctrl  | w_is_caps;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_lshift    <= 1'b0;
         r_rshift    <= 1'b0;
         r_lctrl     <= 1'b0;
         r_rctrl     <= 1'b0;
         r_caps      <= 1'b0;
         r_caps_held <= 1'b0;
      end else if (w_make | w_brk) begin
         if (w_is_lshift) r_lshift <= w_make;
         if (w_is_rshift) r_rshift <= w_make;
         if (w_is_lctrl)  r_lctrl  <= w_make;
         if (w_is_rctrl)  r_rctrl  <= w_make;
         if (w_is_caps) begin
            // Typematic repeats of caps arrive with r_caps_held set
            if (w_make && !r_caps_held && (CAPS_ENABLE != 0)) r_caps <= ~r_caps;
            r_caps_held <= w_make;
         end
      end
   end

   logic [7:0] w_lookup, w_char_case, w_char;
   logic       w_push;
   logic       r_push_valid;
   logic [7:0] r_push_data;

   ps2ascii u_lookup (
      .i_shift  (mod_shift),
      .i_extend (w_ext),
      .i_code   (code_in),
      .o_ascii  (w_lookup)
   );

   assign w_char_case = (r_caps && is_letter(w_lookup)) ? (w_lookup ^ 8'h20) : w_lookup;
   assign w_char      = ((CTRL_ENABLE != 0) && mod_ctrl && is_letter(w_char_case)) ?
                        (w_char_case & 8'h1F) : w_char_case;
   assign w_push      = w_make & ~w_is_mod &
                        (w_lookup != ASCII_NONE) & (w_lookup != ASCII_UNMAPPED);

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_push_valid <= 1'b0;
         r_push_data  <= '0;
      end else begin
         r_push_valid <= w_push;
         r_push_data  <= w_char;
      end
   end

   logic w_fifo_full, w_fifo_empty, w_drop, r_overflow;

   ps2_char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (w_rst_n),
      .i_wr_en   (r_push_valid),
      .i_wr_data (r_push_data),
      .i_rd_en   (ascii_ready),
      .o_rd_data (ascii_data),
      .o_count   (fifo_count),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   // A full FIFO only frees a slot when the consumer pops in the same cycle
   assign w_drop = r_push_valid & w_fifo_full & ~ascii_ready;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)          r_overflow <= 1'b0;
      else if (w_drop)       r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
   end

   assign ascii_valid = ~w_fifo_empty;
   assign caps_lock   = r_caps;
   assign mod_shift   = r_lshift | r_rshift;
   assign mod_ctrl    = r_lctrl | r_rctrl;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: scan-byte vector table with a character
// scoreboard, plus hand sequences for latency, FIFO full/overflow and reset.
module tb_ps2_key_decoder;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    code_in = 8'h00;
   logic          code_valid = 1'b0;
   logic [7:0]    ascii_data;
   logic          ascii_valid;
   logic          ascii_ready = 1'b0;
   logic [CW-1:0] fifo_count;
   logic          caps_lock, mod_shift, mod_ctrl, overflow;
   logic          overflow_clr = 1'b0;

   always #5 clk = ~clk;

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CAPS_ENABLE(1), .CTRL_ENABLE(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .code_in      (code_in),
      .code_valid   (code_valid),
      .ascii_data   (ascii_data),
      .ascii_valid  (ascii_valid),
      .ascii_ready  (ascii_ready),
      .fifo_count   (fifo_count),
      .caps_lock    (caps_lock),
      .mod_shift    (mod_shift),
      .mod_ctrl     (mod_ctrl),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] code;
      logic       push;
      logic [7:0] ch;
      logic       shift;
      logic       ctrl;
      logic       caps;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic v(input logic [7:0] code, input logic push, input logic [7:0] ch,
                    input logic s, input logic c, input logic k);
      vec_t t;
      t.code = code; t.push = push; t.ch = ch; t.shift = s; t.ctrl = c; t.caps = k;
      vecs.push_back(t);
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      code_in = b; code_valid = 1'b1;
      @(posedge clk); #1;
      code_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || ascii_valid) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_drain"}, exp_q.size() + int'(ascii_valid), 0);
   endtask

   // Scoreboard: every handshake pops the oldest expected character
   always @(negedge clk) begin
      if (rst_n && ascii_valid && ascii_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_char: actual 0x%0h required none", ascii_data);
         end else begin
            chk("char", int'(ascii_data), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // shift tests
      v(8'h12,0,8'h00,1,0,0); v(8'h1C,1,8'h41,1,0,0); v(8'hF0,0,8'h00,1,0,0);
      v(8'h12,0,8'h00,0,0,0); v(8'h1C,1,8'h61,0,0,0);
      v(8'h12,0,8'h00,1,0,0); v(8'h16,1,8'h21,1,0,0); v(8'hF0,0,8'h00,1,0,0);
      v(8'h12,0,8'h00,0,0,0);
      v(8'h59,0,8'h00,1,0,0); v(8'h1C,1,8'h41,1,0,0); v(8'hF0,0,8'h00,1,0,0);
      v(8'h59,0,8'h00,0,0,0);
      // caps lock
      v(8'h58,0,8'h00,0,0,1); v(8'hF0,0,8'h00,0,0,1); v(8'h58,0,8'h00,0,0,1);
      v(8'h1C,1,8'h41,0,0,1);
      v(8'h58,0,8'h00,0,0,0); v(8'h58,0,8'h00,0,0,0); v(8'hF0,0,8'h00,0,0,0);
      v(8'h58,0,8'h00,0,0,0);
      v(8'h58,0,8'h00,0,0,1); v(8'hF0,0,8'h00,0,0,1); v(8'h58,0,8'h00,0,0,1);
      v(8'h12,0,8'h00,1,0,1); v(8'h1C,1,8'h61,1,0,1); v(8'hF0,0,8'h00,1,0,1);
      v(8'h12,0,8'h00,0,0,1); v(8'h16,1,8'h31,0,0,1);
      v(8'h14,0,8'h00,0,1,1); v(8'h1C,1,8'h01,0,1,1); v(8'hF0,0,8'h00,0,1,1);
      v(8'h14,0,8'h00,0,0,1);
      v(8'h58,0,8'h00,0,0,0); v(8'hF0,0,8'h00,0,0,0); v(8'h58,0,8'h00,0,0,0);
      // ctrl, left and right
      v(8'h14,0,8'h00,0,1,0); v(8'h21,1,8'h03,0,1,0);
      v(8'hE0,0,8'h00,0,1,0); v(8'h14,0,8'h00,0,1,0);
      v(8'hE0,0,8'h00,0,1,0); v(8'hF0,0,8'h00,0,1,0); v(8'h14,0,8'h00,0,1,0);
      v(8'h21,1,8'h03,0,1,0); v(8'h16,1,8'h31,0,1,0);
      v(8'hF0,0,8'h00,0,1,0); v(8'h14,0,8'h00,0,0,0); v(8'h21,1,8'h63,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'h14,0,8'h00,0,1,0); v(8'h1A,1,8'h1A,0,1,0);
      v(8'hE0,0,8'h00,0,1,0); v(8'hF0,0,8'h00,0,1,0); v(8'h14,0,8'h00,0,0,0);
      // pause sequence, extended keys, ignored bytes, fake shift
      v(8'hE1,0,8'h00,0,0,0); v(8'h14,0,8'h00,0,0,0); v(8'h77,0,8'h00,0,0,0);
      v(8'hE1,0,8'h00,0,0,0); v(8'hF0,0,8'h00,0,0,0); v(8'h14,0,8'h00,0,0,0);
      v(8'hF0,0,8'h00,0,0,0); v(8'h77,0,8'h00,0,0,0); v(8'h1C,1,8'h61,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'h75,0,8'h00,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'h4A,1,8'h2F,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'hF0,0,8'h00,0,0,0); v(8'h4A,0,8'h00,0,0,0);
      v(8'hAA,0,8'h00,0,0,0); v(8'hFA,0,8'h00,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'h12,0,8'h00,0,0,0);
      v(8'hE0,0,8'h00,0,0,0); v(8'hF0,0,8'h00,0,0,0); v(8'h12,0,8'h00,0,0,0);
      v(8'h05,0,8'h00,0,0,0); v(8'h5A,1,8'h0D,0,0,0); v(8'h1C,1,8'h61,0,0,0);

      // reset state
      #12;
      chk("rst_valid", ascii_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_data", ascii_data, 0);
      chk("rst_caps", caps_lock, 0);
      chk("rst_mods", {mod_shift, mod_ctrl}, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // first character latency, then a break that must not push
      ascii_ready = 1'b0;
      code_in = 8'h1C; code_valid = 1'b1; exp_q.push_back(8'h61);
      @(posedge clk); #1;
      code_valid = 1'b0;
      chk("lat_n1_valid", ascii_valid, 0);
      @(posedge clk); #1;
      chk("lat_n2_valid", ascii_valid, 1);
      chk("lat_n2_data", ascii_data, 8'h61);
      send(8'hF0); send(8'h1C);
      repeat (3) @(posedge clk);
      #1;
      chk("brk_count", fifo_count, 1);
      chk("brk_mods", {mod_shift, mod_ctrl}, 0);
      ascii_ready = 1'b1;
      wait_drain("t1");

      // table, driven back-to-back
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         if (i > 0) begin
            chk($sformatf("v%0d_shift", i-1), mod_shift, vecs[i-1].shift);
            chk($sformatf("v%0d_ctrl",  i-1), mod_ctrl,  vecs[i-1].ctrl);
            chk($sformatf("v%0d_caps",  i-1), caps_lock, vecs[i-1].caps);
         end
         code_in = vecs[i].code; code_valid = 1'b1;
         if (vecs[i].push) exp_q.push_back(vecs[i].ch);
      end
      @(posedge clk); #1;
      code_valid = 1'b0;
      chk("vlast_shift", mod_shift, vecs[vecs.size()-1].shift);
      chk("vlast_ctrl",  mod_ctrl,  vecs[vecs.size()-1].ctrl);
      chk("vlast_caps",  caps_lock, vecs[vecs.size()-1].caps);
      wait_drain("table");

      // fill to full, ninth key dropped
      ascii_ready = 1'b0;
      begin
         logic [7:0] keys [9];
         keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
         for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            code_in = keys[i]; code_valid = 1'b1;
            if (i < 8) exp_q.push_back(8'h61 + 8'(i));
         end
      end
      @(posedge clk); #1;
      code_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("full_count", fifo_count, 8);
      chk("full_ovf", overflow, 1);
      chk("full_head", ascii_data, 8'h61);

      // push and pop in the same cycle while full
      code_in = 8'h3B; code_valid = 1'b1; exp_q.push_back(8'h6A);
      @(posedge clk); #1;
      code_valid = 1'b0; ascii_ready = 1'b1;
      @(posedge clk); #1;
      ascii_ready = 1'b0;
      chk("pushpop_count", fifo_count, 8);
      chk("pushpop_head", ascii_data, 8'h62);

      @(posedge clk); #1; overflow_clr = 1'b1;
      @(posedge clk); #1; overflow_clr = 1'b0;
      chk("ovf_clr", overflow, 0);

      // drop and clear in the same cycle: drop wins
      code_in = 8'h43; code_valid = 1'b1;
      @(posedge clk); #1;
      code_valid = 1'b0; overflow_clr = 1'b1;
      @(posedge clk); #1;
      overflow_clr = 1'b0;
      chk("drop_wins_ovf", overflow, 1);
      chk("drop_wins_count", fifo_count, 8);
      @(posedge clk); #1; overflow_clr = 1'b1;
      @(posedge clk); #1; overflow_clr = 1'b0;
      chk("ovf_clr2", overflow, 0);
      ascii_ready = 1'b1;
      wait_drain("full");

      // reset in the middle of an E0 prefix
      send(8'h58); send(8'hF0); send(8'h58); send(8'h12);
      ascii_ready = 1'b0;
      send(8'h1C);
      send(8'hE0);
      #2;
      rst_n = 1'b0;
      #2;
      exp_q.delete();
      chk("mid_rst_valid", ascii_valid, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_caps", caps_lock, 0);
      chk("mid_rst_shift", mod_shift, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ascii_ready = 1'b1;
      exp_q.push_back(8'h61);
      send(8'h1C);
      wait_drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
